four_port_switch: RTL and testbench

Four-port packet switch with per-port input FIFOs and per-output round-robin arbitration. It is the top-level datapath block under the packet verification environment. It accepts one 16-bit packet per port per cycle and delivers each packet to every port in its target mask: unicast, multicast or broadcast. Packets arriving at a full FIFO are dropped at the input.

---
 rtl/packet_pkg.sv | 66 ++++++
 rtl/sw_arbiter.sv | 42 ++++
 rtl/sw_fifo.sv | 57 +++++
 rtl/sw_port.sv | 83 ++++++++
 rtl/four_port_switch.sv | 108 ++++++++++
 tb/tb_four_port_switch.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/packet_pkg.sv
// Shared types and constants for the four-port packet switch.
// Packet layout is {data[7:0], target[3:0], source[3:0]}.
package packet_pkg;

  localparam int NUM_PORTS    = 4;
  localparam int DEPTH        = 8;
  localparam int PACKET_WIDTH = 16;
  localparam int PTR_WIDTH    = $clog2(DEPTH);
  localparam int COUNT_WIDTH  = $clog2(DEPTH + 1);

  // Header field slices inside a stored packet
  localparam int SOURCE_LSB = 0;
  localparam int SOURCE_MSB = 3;
  localparam int TARGET_LSB = 4;
  localparam int TARGET_MSB = 7;
  localparam int DATA_LSB   = 8;
  localparam int DATA_MSB   = 15;

  typedef enum logic [1:0] {
    UNICAST,
    MULTICAST,
    BROADCAST,
    INVALID
  } pkt_type_e;

  typedef enum logic {
    IDLE,
    SERVE
  } port_state_e;

  // Number of set bits in a 4-bit mask
  function automatic logic [2:0] popcount4(input logic [3:0] mask);
    return {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};
  endfunction

  // Classify a packet by how many outputs its target mask names
  function automatic pkt_type_e decode_type(input logic [3:0] target);
    case (popcount4(target))
      3'd1:       return UNICAST;
      3'd2, 3'd3: return MULTICAST;
      3'd4:       return BROADCAST;
      default:    return INVALID;
    endcase
  endfunction

  // Sender ids are one-hot; anything else marks a corrupt header
  function automatic logic source_is_one_hot(input logic [3:0] source);
    return popcount4(source) == 3'd1;
  endfunction

  // Pointer increment that wraps at DEPTH even if DEPTH is not a power of two
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    if (ptr == PTR_WIDTH'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_WIDTH'(1);
  endfunction

  // Assemble the stored packet word from its fields
  function automatic logic [PACKET_WIDTH-1:0] pack_packet(input logic [3:0] source,
                                                          input logic [3:0] target,
                                                          input logic [7:0] data);
    return {data, target, source};
  endfunction

endpackage

// File: rtl/sw_arbiter.sv
// Round-robin arbiter for one output: picks one requesting input per cycle,
// then moves priority to the input after the one it granted.
module sw_arbiter
  import packet_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] request,
  output logic [3:0] grant
);

  logic [1:0] ptr;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       found;

  // Scan inputs starting at the priority pointer and grant the first requester
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    cand      = ptr;
    found     = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = ptr + 2'(i);
      if (!found && request[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  // Priority pointer: stays put when idle, otherwise points past the winner
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= grant_idx + 2'd1;
    end
  end

endmodule

// File: rtl/sw_fifo.sv
// Per-port input FIFO: first-word fall-through head, registered occupancy count.
// Writes while full are refused even if a pop happens in the same cycle.
module sw_fifo
  import packet_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [PACKET_WIDTH-1:0] wr_data,
  input  logic                    rd_en,
  output logic [PACKET_WIDTH-1:0] rd_data,
  output logic [COUNT_WIDTH-1:0]  count
);

  logic [PACKET_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]    wr_ptr;
  logic [PTR_WIDTH-1:0]    rd_ptr;
  logic                    full;
  logic                    empty;
  logic                    do_write;
  logic                    do_read;

  assign full     = (count == COUNT_WIDTH'(DEPTH));
  assign empty    = (count == '0);
  assign do_write = wr_en && !full;
  assign do_read  = rd_en && !empty;
  assign rd_data  = mem[rd_ptr];

  // Storage array; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous write and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_read) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_write, do_read})
        2'b10:   count <= count + COUNT_WIDTH'(1);
        2'b01:   count <= count - COUNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sw_port.sv
// One switch input: admission filter, input FIFO and the IDLE/SERVE service FSM.
// The head packet stays in the FIFO until every output in its mask has taken it.
module sw_port
  import packet_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [3:0] source_in,
  input  logic [3:0] target_in,
  input  logic [7:0] data_in,
  input  logic [3:0] grant,
  output logic [3:0] request,
  output logic [3:0] head_source,
  output logic [3:0] head_target,
  output logic [7:0] head_data
);

  pkt_type_e               pkt_type;
  port_state_e             current_state;
  logic                    accept;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [COUNT_WIDTH-1:0]  fifo_count;
  logic [PACKET_WIDTH-1:0] head;
  logic [3:0]              pending;
  logic [3:0]              remaining;
  logic                    pop;

  assign pkt_type   = decode_type(target_in);
  assign fifo_full  = (fifo_count == COUNT_WIDTH'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign accept     = valid_in && (pkt_type != INVALID) && source_is_one_hot(source_in)
                      && !fifo_full;

  assign head_source = head[SOURCE_MSB:SOURCE_LSB];
  assign head_target = head[TARGET_MSB:TARGET_LSB];
  assign head_data   = head[DATA_MSB:DATA_LSB];

  assign request   = pending;
  assign remaining = pending & ~grant;
  assign pop       = (current_state == SERVE) && (remaining == '0);

  sw_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (pack_packet(source_in, target_in, data_in)),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  // Service FSM: latch the head mask, then clear bits as outputs grant them
  always_ff @(posedge clk) begin
    if (rst) begin
      current_state <= IDLE;
      pending       <= '0;
    end else begin
      case (current_state)
        IDLE: begin
          if (!fifo_empty) begin
            current_state <= SERVE;
            pending       <= head_target;
          end
        end
        SERVE: begin
          if (remaining == '0) begin
            current_state <= IDLE;
            pending       <= '0;
          end else begin
            pending <= remaining;
          end
        end
        default: begin
          current_state <= IDLE;
          pending       <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/four_port_switch.sv
// Four-port packet switch: per-input FIFOs and FSMs, one round-robin arbiter
// per output, and registered delivery of the granted head packet.
module four_port_switch
  import packet_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      valid_in,
  input  logic [3:0][3:0] source_in,
  input  logic [3:0][3:0] target_in,
  input  logic [3:0][7:0] data_in,
  output logic [3:0]      valid_out,
  output logic [3:0][3:0] source_out,
  output logic [3:0][3:0] target_out,
  output logic [3:0][7:0] data_out
);

  logic [3:0][3:0] port_request;
  logic [3:0][3:0] port_grant;
  logic [3:0][3:0] arb_request;
  logic [3:0][3:0] arb_grant;
  logic [3:0][3:0] head_source;
  logic [3:0][3:0] head_target;
  logic [3:0][7:0] head_data;
  logic [3:0]      sel_valid;
  logic [3:0][3:0] sel_source;
  logic [3:0][3:0] sel_target;
  logic [3:0][7:0] sel_data;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    sw_port u_port (
      .clk         (clk),
      .rst         (rst),
      .valid_in    (valid_in[p]),
      .source_in   (source_in[p]),
      .target_in   (target_in[p]),
      .data_in     (data_in[p]),
      .grant       (port_grant[p]),
      .request     (port_request[p]),
      .head_source (head_source[p]),
      .head_target (head_target[p]),
      .head_data   (head_data[p])
    );
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_arb
    sw_arbiter u_arb (
      .clk     (clk),
      .rst     (rst),
      .request (arb_request[k]),
      .grant   (arb_grant[k])
    );
  end

  // Regroup per-input request masks into per-output request vectors
  always_comb begin
    arb_request = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        arb_request[k][p] = port_request[p][k];
      end
    end
  end

  // Regroup per-output grants into the set of outputs granting each input
  always_comb begin
    port_grant = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        port_grant[p][k] = arb_grant[k][p];
      end
    end
  end

  // Select the head packet of whichever input each output granted
  always_comb begin
    sel_valid  = '0;
    sel_source = '0;
    sel_target = '0;
    sel_data   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (arb_grant[k][p]) begin
          sel_valid[k]  = 1'b1;
          sel_source[k] = head_source[p];
          sel_target[k] = head_target[p];
          sel_data[k]   = head_data[p];
        end
      end
    end
  end

  // Output registers: one-cycle strobe with the full original header
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= '0;
      source_out <= '0;
      target_out <= '0;
      data_out   <= '0;
    end else begin
      valid_out  <= sel_valid;
      source_out <= sel_source;
      target_out <= sel_target;
      data_out   <= sel_data;
    end
  end

endmodule

// File: tb/tb_four_port_switch.sv
// Testbench for four_port_switch: directed vector table, hand-written corner
// sequences and random traffic against a queue-based delivery model.
module tb_four_port_switch;
  import packet_pkg::*;

  logic            clk;
  logic            rst;
  logic [3:0]      valid_in;
  logic [3:0][3:0] source_in;
  logic [3:0][3:0] target_in;
  logic [3:0][7:0] data_in;
  logic [3:0]      valid_out;
  logic [3:0][3:0] source_out;
  logic [3:0][3:0] target_out;
  logic [3:0][7:0] data_out;

  int checks = 0;
  int errors = 0;

  four_port_switch dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .source_in  (source_in),
    .target_in  (target_in),
    .data_in    (data_in),
    .valid_out  (valid_out),
    .source_out (source_out),
    .target_out (target_out),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] probe_count [4];
  logic [3:0] probe_idle;
  logic [3:0] probe_full;

  assign probe_count[0] = dut.g_port[0].u_port.fifo_count;
  assign probe_count[1] = dut.g_port[1].u_port.fifo_count;
  assign probe_count[2] = dut.g_port[2].u_port.fifo_count;
  assign probe_count[3] = dut.g_port[3].u_port.fifo_count;
  assign probe_idle[0]  = (dut.g_port[0].u_port.current_state == IDLE);
  assign probe_idle[1]  = (dut.g_port[1].u_port.current_state == IDLE);
  assign probe_idle[2]  = (dut.g_port[2].u_port.current_state == IDLE);
  assign probe_idle[3]  = (dut.g_port[3].u_port.current_state == IDLE);
  assign probe_full[0]  = dut.g_port[0].u_port.fifo_full;
  assign probe_full[1]  = dut.g_port[1].u_port.fifo_full;
  assign probe_full[2]  = dut.g_port[2].u_port.fifo_full;
  assign probe_full[3]  = dut.g_port[3].u_port.fifo_full;

  // Reference model: each input's accepted packets in arrival order, with the
  // outputs still owed a copy. A packet leaves the model FIFO when none remain.
  typedef struct {
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
    logic [3:0] remaining;
  } pkt_t;

  pkt_t sb_q [4][$];
  int   drops [4];
  logic rst_seen;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic sb_deliver(input int k);
    logic [3:0] src;
    int         p;
    pkt_t       h;
    src = source_out[k];
    checks++;
    if ($countones(src) != 1) begin
      errors++;
      $display("[TB] FAIL sb_source: output %0d source %b, required one-hot", k, src);
      return;
    end
    p = 0;
    for (int i = 0; i < 4; i++) if (src[i]) p = i;
    if (sb_q[p].size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_unexpected: output %0d delivered src %b tgt %b data %h, required none",
               k, src, target_out[k], data_out[k]);
      return;
    end
    h = sb_q[p][0];
    if (h.tgt !== target_out[k] || h.data !== data_out[k] || !h.remaining[k]) begin
      errors++;
      $display("[TB] FAIL sb_packet: output %0d got src %b tgt %b data %h, required src %b tgt %b data %h owed %b",
               k, src, target_out[k], data_out[k], h.src, h.tgt, h.data, h.remaining);
      return;
    end
    h.remaining[k] = 1'b0;
    if (h.remaining == '0) void'(sb_q[p].pop_front());
    else sb_q[p][0] = h;
  endtask

  // Model update: admit packets at each edge, then account for what came out
  always begin
    @(posedge clk);
    rst_seen = rst;
    if (rst) begin
      for (int p = 0; p < 4; p++) sb_q[p].delete();
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (valid_in[p] && target_in[p] != 4'b0000 && $countones(source_in[p]) == 1) begin
          if (sb_q[p].size() < DEPTH)
            sb_q[p].push_back('{src: source_in[p], tgt: target_in[p], data: data_in[p],
                                remaining: target_in[p]});
          else
            drops[p]++;
        end
      end
    end
    #1;
    if (rst_seen) begin
      check("reset_outputs_zero", 72'({valid_out, source_out, target_out, data_out}), 72'(0));
    end else begin
      for (int k = 0; k < 4; k++) if (valid_out[k]) sb_deliver(k);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in  = '0;
    source_in = '0;
    target_in = '0;
    data_in   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int p, input logic [3:0] src, input logic [3:0] tgt,
                               input logic [7:0] data);
    valid_in[p]  = 1'b1;
    source_in[p] = src;
    target_in[p] = tgt;
    data_in[p]   = data;
  endtask

  task automatic checkOutput(input string name, input int k, input logic [3:0] src,
                             input logic [3:0] tgt, input logic [7:0] data);
    check(name, 72'({valid_out[k], source_out[k], target_out[k], data_out[k]}),
          72'({1'b1, src, tgt, data}));
  endtask

  typedef struct {
    int         port;
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
    logic [3:0] exp_mask;
    logic [3:0] exp_count;
  } vec_t;

  vec_t vecs [7];
  logic saw_full;
  int   drops_before;

  initial begin
    vecs[0] = '{port: 0, src: 4'b0001, tgt: 4'b0100, data: 8'hA5, exp_mask: 4'b0100, exp_count: 4'd1};
    vecs[1] = '{port: 1, src: 4'b0010, tgt: 4'b1111, data: 8'h3C, exp_mask: 4'b1111, exp_count: 4'd1};
    vecs[2] = '{port: 3, src: 4'b1000, tgt: 4'b0110, data: 8'h5A, exp_mask: 4'b0110, exp_count: 4'd1};
    vecs[3] = '{port: 2, src: 4'b0100, tgt: 4'b0100, data: 8'h77, exp_mask: 4'b0100, exp_count: 4'd1};
    vecs[4] = '{port: 2, src: 4'b0100, tgt: 4'b0000, data: 8'h11, exp_mask: 4'b0000, exp_count: 4'd0};
    vecs[5] = '{port: 2, src: 4'b0011, tgt: 4'b0001, data: 8'h22, exp_mask: 4'b0000, exp_count: 4'd0};
    vecs[6] = '{port: 1, src: 4'b0010, tgt: 4'b1011, data: 8'hC3, exp_mask: 4'b1011, exp_count: 4'd1};
    for (int p = 0; p < 4; p++) drops[p] = 0;

    rst = 1'b1;
    clear_inputs();

    // Reset held 10 cycles with traffic toggling on every port
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < 4; p++)
        applyStimulus(p, 4'(1 << p), 4'b1111, 8'(i));
      if (i % 2 == 1) valid_in = '0;
      tick();
      check("reset_valid_out", 72'(valid_out), 72'(0));
    end
    for (int p = 0; p < 4; p++) begin
      check("reset_fifo_count", 72'(probe_count[p]), 72'(0));
      check("reset_fsm_idle", 72'(probe_idle[p]), 72'(1));
    end
    rst = 1'b0;
    clear_inputs();
    tick();
    check("after_reset_quiet", 72'(valid_out), 72'(0));

    // Single-packet vectors: exact two-edge latency and one-cycle strobe
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      applyStimulus(vecs[i].port, vecs[i].src, vecs[i].tgt, vecs[i].data);
      tick();
      check("vec_count_after_write", 72'(probe_count[vecs[i].port]), 72'(vecs[i].exp_count));
      clear_inputs();
      tick();
      check("vec_not_early", 72'(valid_out), 72'(0));
      tick();
      check("vec_out_mask", 72'(valid_out), 72'(vecs[i].exp_mask));
      for (int k = 0; k < 4; k++)
        if (vecs[i].exp_mask[k]) checkOutput("vec_fields", k, vecs[i].src, vecs[i].tgt, vecs[i].data);
      tick();
      check("vec_single_cycle", 72'(valid_out), 72'(0));
      check("vec_fifo_drained", 72'(probe_count[vecs[i].port]), 72'(0));
    end

    // Contention: four inputs to output 0, served in order 0,1,2,3 after reset
    do_reset();
    for (int p = 0; p < 4; p++) applyStimulus(p, 4'(1 << p), 4'b0001, 8'(8'h40 + p));
    tick();
    clear_inputs();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("contention_order", 0, 4'(1 << i), 4'b0001, 8'(8'h40 + i));
    end
    tick();
    check("contention_done", 72'(valid_out), 72'(0));

    // Overflow: port3 bursts 10 packets to output 0 while ports 0-2 keep it busy
    do_reset();
    saw_full     = 1'b0;
    drops_before = drops[3];
    for (int c = 0; c < 14; c++) begin
      clear_inputs();
      for (int p = 0; p < 3; p++) applyStimulus(p, 4'(1 << p), 4'b0001, 8'(c));
      if (c < 10) applyStimulus(3, 4'b1000, 4'b0001, 8'(8'h80 + c));
      tick();
      if (probe_full[3]) saw_full = 1'b1;
    end
    clear_inputs();
    for (int c = 0; c < 120; c++) tick();
    check("overflow_full_seen", 72'(saw_full), 72'(1));
    check("overflow_dropped", 72'(drops[3] - drops_before >= 1), 72'(1));
    for (int p = 0; p < 4; p++) check("overflow_all_delivered", 72'(sb_q[p].size()), 72'(0));

    // Random traffic with a reset in the middle
    do_reset();
    for (int c = 0; c < 300; c++) begin
      rst = (c == 150 || c == 151);
      clear_inputs();
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 9) < 4) begin
          applyStimulus(p, ($urandom_range(0, 9) == 0) ? 4'b0011 : 4'(1 << p),
                        4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
      end
      tick();
      if (c == 152) check("mid_reset_quiet", 72'(valid_out), 72'(0));
    end
    rst = 1'b0;
    clear_inputs();
    for (int c = 0; c < 150; c++) tick();
    for (int p = 0; p < 4; p++) begin
      check("random_all_delivered", 72'(sb_q[p].size()), 72'(0));
      check("random_fifo_empty", 72'(probe_count[p]), 72'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
